// File: rtl/mul_sequencer_pkg.sv
// mul_sequencer_pkg: shared state encodings and default width for the multiplier sequencer
package mul_sequencer_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: request/result bundle between the CPU and the multiplier sequencer
import mul_sequencer_pkg::*;
interface mul_sequencer_if #(parameter int WIDTH = WIDTH_DEF);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] product;
  logic ovf;
  modport master (output start, a, b, input busy, done, product, ovf);
  modport slave (input start, a, b, output busy, done, product, ovf);
endinterface

// File: rtl/mul_sequencer_adder.sv
// mul_sequencer_adder: the shared 8-bit adder, sum wraps mod 256
module mul_sequencer_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] out
);
  assign out = a + b;
endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: shift-add a*b mod 2^WIDTH with overflow flag on the shared adder
// MUL_EARLY_EXIT_EN stops RUN once no multiplier bits remain
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic clk,
  input logic reset,
  mul_sequencer_if.slave bus
);
  localparam int IW = $clog2(WIDTH) + 1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, product_q, product_d, sum;
  logic ovf_acc_q, ovf_acc_d, ovf_q, ovf_d, fin;
  logic [IW-1:0] iter_q, iter_d;
  mul_sequencer_adder u_adder (.a(acc_q), .b(mcand_q), .out(sum));
`ifdef MUL_EARLY_EXIT_EN
  assign fin = (iter_q == IW'(WIDTH - 1)) | ~|(mplier_q >> 1);
`else
  assign fin = iter_q == IW'(WIDTH - 1);
`endif
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    ovf_acc_d = ovf_acc_q;
    iter_d = iter_q;
    product_d = product_q;
    ovf_d = ovf_q;
    if (state_q == IDLE && bus.start) begin
      state_d = RUN;
      mcand_d = bus.a;
      mplier_d = bus.b;
      acc_d = '0;
      ovf_acc_d = 1'b0;
      iter_d = '0;
    end else if (state_q == RUN) begin
      acc_d = mplier_q[0] ? sum : acc_q;
      // carry out of the add, or a multiplicand bit shifted out that a later multiplier bit needs
      ovf_acc_d = ovf_acc_q | (mplier_q[0] & (sum < acc_q)) | (mcand_q[WIDTH-1] & |(mplier_q >> 1));
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      iter_d = iter_q + IW'(1);
      if (fin) begin
        state_d = DONE;
        product_d = acc_d;
        ovf_d = ovf_acc_d;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      ovf_acc_q <= 1'b0;
      iter_q <= '0;
      product_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      ovf_acc_q <= ovf_acc_d;
      iter_q <= iter_d;
      product_q <= product_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == DONE;
  assign bus.product = product_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed and random operands against an arithmetic reference model
module tb_mul_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [7:0] last_p = 8'd0;
  logic last_o = 1'b0;
  mul_sequencer_if bus ();
  mul_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int exp_lat(input logic [7:0] y);
    int it = 8;
`ifdef MUL_EARLY_EXIT_EN
    it = 1;
    for (int i = 0; i < 8; i++) if (y[i]) it = i + 1;
`endif
    return it + 1;
  endfunction
  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input string tag);
    int n = 0;
    int busy_n = 0;
    int hold_bad = 0;
    int full = int'(x) * int'(y);
    bit got = 0;
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a = ~x;
      bus.b = ~y;
      n++;
      if (bus.busy) busy_n++;
      if (bus.done) got = 1;
      else if (bus.product !== last_p || bus.ovf !== last_o) hold_bad++;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, n, exp_lat(y));
    chk({tag, "_busy_cycles"}, busy_n, exp_lat(y) - 1);
    chk({tag, "_busy_with_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_hold"}, hold_bad, 0);
    chk({tag, "_product"}, 32'(bus.product), 32'(full % 256));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(full >= 256));
    last_p = 8'(full % 256);
    last_o = full >= 256;
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_product_hold"}, 32'(bus.product), 32'(last_p));
  endtask
  initial begin
    int dones;
    bus.start = 1'b0;
    bus.a = 8'd0;
    bus.b = 8'd0;
    #12;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_product", 32'(bus.product), 32'd0);
    chk("reset_ovf", 32'(bus.ovf), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    do_op(8'd0, 8'd0, "zero");
    do_op(8'd6, 8'd7, "six_seven");
    do_op(8'd16, 8'd16, "sixteen_sq");
    do_op(8'd32, 8'd8, "lost_bit");
    do_op(8'd15, 8'd17, "max_no_ovf");
    do_op(8'd255, 8'd255, "all_ones");
    do_op(8'd255, 8'd1, "ovf_cleared");
    // second start lands mid-RUN and must be dropped
    bus.a = 8'd3;
    bus.b = 8'd5;
    bus.start = 1'b1;
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      bus.start = (k == 2);
      bus.a = (k == 2) ? 8'd9 : 8'd0;
      bus.b = (k == 2) ? 8'd9 : 8'd0;
      if (bus.done) begin
        dones++;
        chk("ignored_start_product", 32'(bus.product), 32'd15);
      end
    end
    bus.start = 1'b0;
    chk("ignored_start_dones", dones, 1);
    last_p = 8'd15;
    last_o = 1'b0;
    do_op(8'd128, 8'd2, "top_bit");
    bus.a = 8'd200;
    bus.b = 8'd3;
    bus.start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    chk("midrun_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrun_busy", 32'(bus.busy), 32'd0);
    chk("midrun_done", 32'(bus.done), 32'd0);
    chk("midrun_product", 32'(bus.product), 32'd0);
    chk("midrun_ovf", 32'(bus.ovf), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_p = 8'd0;
    last_o = 1'b0;
    @(posedge clk);
    #1;
    do_op(8'd2, 8'd3, "after_reset");
    for (int r = 0; r < 25; r++) do_op(8'($urandom), 8'($urandom), "random");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
